ascii_uart_tx: RTL and testbench

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

---
 rtl/ascii_uart_tx_pkg.sv | 44 ++++
 rtl/ascii_uart_tx_if.sv | 26 ++
 rtl/uart_tx_byte.sv | 95 +++++++++
 rtl/ascii_uart_tx.sv | 74 +++++++
 tb/tb_ascii_uart_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_uart_tx_pkg.sv
// Shared constants for the ASCII mnemonic UART transmitter: FSM encoding, line terminators,
// default bit timing and the character-selection helpers.
package ascii_uart_tx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Character index 0..4 selects a mnemonic slot, 5 is CR, 6 is LF, 7 marks end of line.
    localparam logic [2:0] IdxDone = 3'd7;

    function automatic logic [7:0] char_at(input logic [39:0] word, input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = word[39:32];
            3'd1:    c = word[31:24];
            3'd2:    c = word[23:16];
            3'd3:    c = word[15:8];
            3'd4:    c = word[7:0];
            3'd5:    c = CHAR_CR;
            default: c = CHAR_LF;
        endcase
        return c;
    endfunction

    // Index of the first non-zero slot from the top, or 5 (CR) for an all-zero word.
    function automatic logic [2:0] lead_zeros(input logic [39:0] word);
        logic [2:0] n;
        n = 3'd5;
        for (int i = 0; i < 5; i++) begin
            if (word[8*i +: 8] != 8'h00) begin
                n = 3'(4 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ascii_uart_tx_if.sv
// Mnemonic handshake plus serial line of the ASCII UART transmitter.
interface ascii_uart_tx_if;

    logic        valid_i;
    logic [39:0] ascii_i;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;

    modport master (
        output valid_i,
        output ascii_i,
        input  ready_o,
        input  tx_o,
        input  busy_o
    );

    modport slave (
        input  valid_i,
        input  ascii_i,
        output ready_o,
        output tx_o,
        output busy_o
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. done pulses in the final stop-bit cycle; a start seen in that same
// cycle chains the next byte with no idle gap.
module uart_tx_byte
    import ascii_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntMax);
    assign done    = (state_q == StStop) && bit_end;
    assign tx      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StStart;
                    shreg_d = data;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (start) begin
                        state_d = StStart;
                        shreg_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// Sends a right-aligned 5-character mnemonic over UART, skipping leading NULs and ending the
// line with CR LF. Sequencing lives here; bit timing lives in uart_tx_byte.
module ascii_uart_tx
    import ascii_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    ascii_uart_tx_if.slave  bus
);

    logic        busy_q, busy_d;
    logic [39:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  lead;
    logic        accept;
    logic        byte_start;
    logic        byte_done;
    logic        byte_tx;
    logic [7:0]  byte_data;

    assign lead   = lead_zeros(bus.ascii_i);
    assign accept = bus.valid_i && !busy_q;

    // The first byte is picked straight from ascii_i so its start bit begins right after acceptance.
    assign byte_start = accept || (byte_done && (idx_q != IdxDone));
    assign byte_data  = accept ? char_at(bus.ascii_i, lead) : char_at(word_q, idx_q);

    always_comb begin
        busy_d = busy_q;
        word_d = word_q;
        idx_d  = idx_q;
        if (accept) begin
            busy_d = 1'b1;
            word_d = bus.ascii_i;
            idx_d  = lead + 3'd1;
        end else if (byte_done) begin
            if (idx_q == IdxDone) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            busy_q <= busy_d;
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (byte_tx),
        .done  (byte_done)
    );

    assign bus.ready_o = !busy_q;
    assign bus.busy_o  = busy_q;
    assign bus.tx_o    = byte_tx;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Bench for ascii_uart_tx: cycle-accurate waveform model, UART receiver, directed and random lines.
module tb_ascii_uart_tx;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ascii_uart_tx_if bus ();

    ascii_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Bytes a word produces on the line: leading NULs dropped, then CR LF.
    function automatic int line_bytes(input logic [39:0] w, output logic [7:0] b [7]);
        int n;
        bit seen;
        logic [7:0] c;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) b[i] = 8'h00;
        for (int s = 0; s < 5; s++) begin
            c = w[39-8*s -: 8];
            if (c != 8'h00) seen = 1'b1;
            if (seen) begin
                b[n] = c;
                n++;
            end
        end
        b[n]   = 8'h0D;
        b[n+1] = 8'h0A;
        return n + 2;
    endfunction

    // Expected tx_o, one entry per clock cycle; front entry is the current cycle.
    logic q_tx[$];
    bit   model_live = 1'b0;

    function automatic void push_line(input logic [39:0] w);
        logic [7:0] b [7];
        int n;
        n = line_bytes(w, b);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) q_tx.push_back(1'b0);
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < CPB; c++) q_tx.push_back(b[i][k]);
            for (int c = 0; c < CPB; c++) q_tx.push_back(1'b1);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_tx.delete();
            model_live = 1'b1;
        end else if (q_tx.size() == 0) begin
            if (bus.valid_i) push_line(bus.ascii_i);
        end else begin
            void'(q_tx.pop_front());
        end
    end

    always @(negedge clk) begin
        logic exp_tx;
        logic exp_rdy;
        if (model_live) begin
            exp_rdy = (q_tx.size() == 0);
            exp_tx  = exp_rdy ? 1'b1 : q_tx[0];
            check("tx_o", bus.tx_o, exp_tx);
            check("ready_o", bus.ready_o, exp_rdy);
            check("busy_o", bus.busy_o, !exp_rdy);
        end
    end

    // Mid-bit sampling receiver.
    int         rx_cnt = -1;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        int j;
        if (rst || !model_live) begin
            rx_cnt = -1;
        end else begin
            if (rx_cnt < 0 && bus.tx_o === 1'b0) rx_cnt = 0;
            if (rx_cnt >= 0) begin
                if (rx_cnt % CPB == CPB / 2) begin
                    j = rx_cnt / CPB;
                    if (j == 0) begin
                        check("start bit", bus.tx_o, 1'b0);
                    end else if (j <= 8) begin
                        rx_sh[j-1] = bus.tx_o;
                    end else begin
                        check("stop bit", bus.tx_o, 1'b1);
                        rx_q.push_back(rx_sh);
                    end
                end
                rx_cnt++;
                if (rx_cnt == 10 * CPB) rx_cnt = -1;
            end
        end
    end

    function automatic logic [39:0] rand_word();
        logic [39:0] w;
        int k;
        int s;
        w = {8'($urandom), 32'($urandom)};
        k = $urandom_range(0, 5);
        for (int i = 0; i < k; i++) w[39-8*i -: 8] = 8'h00;
        if ($urandom % 4 == 0) begin
            s = $urandom_range(0, 4);
            w[39-8*s -: 8] = 8'h00;
        end
        return w;
    endfunction

    task automatic check_rx(input string name, input int cnt, input logic [55:0] exp);
        check({name, " byte count"}, rx_q.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < rx_q.size())
                check({name, " byte"}, rx_q[i], 8'(exp >> (8 * (cnt - 1 - i))));
        end
    endtask

    // Pulses valid_i for one cycle, then scribbles ascii_i while the line is in flight.
    task automatic send_line(input string name, input logic [39:0] w, input int exp_cycles,
                             input int cnt, input logic [55:0] exp);
        int n;
        rx_q.delete();
        check({name, " ready before"}, bus.ready_o, 1'b1);
        bus.valid_i = 1'b1;
        bus.ascii_i = w;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.ascii_i = rand_word();
        n = 1;
        while (!bus.ready_o && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " ready cycle"}, n, exp_cycles);
        check_rx(name, cnt, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b [7];
        int n;

        bus.valid_i = 1'b0;
        bus.ascii_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_o", bus.tx_o, 1'b1);
        check("reset ready_o", bus.ready_o, 1'b1);
        check("reset busy_o", bus.busy_o, 1'b0);

        n = line_bytes(40'h0000414E44, b);
        check("model AND count", n, 5);
        check("model AND first", b[0], 8'h41);
        check("model AND last", b[4], 8'h0A);
        n = line_bytes(40'h0, b);
        check("model zero count", n, 2);
        check("model zero first", b[0], 8'h0D);
        n = line_bytes(40'h0041004200, b);
        check("model interior nul count", n, 6);
        check("model interior nul", b[1], 8'h00);

        rst = 1'b0;
        @(posedge clk);
        #1;

        send_line("AND", 40'h0000414E44, 201, 5, 56'h414E440D0A);
        send_line("ADDIU", 40'h4144444955, 281, 7, 56'h41444449550D0A);
        send_line("zero", 40'h0, 81, 2, 56'h0D0A);
        send_line("J", 40'h000000004A, 121, 3, 56'h4A0D0A);
        send_line("trail nul", 40'h0041004200, 241, 6, 56'h410042000D0A);

        // Reset during data bit 3 of the second byte (cycles 57..60 after acceptance).
        rx_q.delete();
        bus.valid_i = 1'b1;
        bus.ascii_i = 40'h0000414E44;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (57) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        check("mid rst tx_o", bus.tx_o, 1'b1);
        check("mid rst ready_o", bus.ready_o, 1'b1);
        check("mid rst busy_o", bus.busy_o, 1'b0);
        check_rx("before rst", 1, 56'h41);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        send_line("OR", 40'h0000004F52, 161, 4, 56'h4F520D0A);

        // valid_i held high with changing words.
        bus.valid_i = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            bus.ascii_i = (c % 2 == 0) ? 40'h0000414E44 : rand_word();
            @(posedge clk);
            #1;
        end

        // Random pulses and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bus.valid_i = ($urandom % 8 == 0);
            bus.ascii_i = rand_word();
            rst = ($urandom % 500 == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.valid_i = 1'b0;
        n = 0;
        while (!bus.ready_o && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain ready_o", bus.ready_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
